// File: rtl/id_stage_pipe.sv
// MIPS decode stage: field extraction, operand select, branch resolution, ID/EX register
// with valid/ready handshake and post-branch squash. Define ID_HAZARD_EN for load-use stalls.
module id_stage_pipe #(
  parameter int DATA_W    = 32,
  parameter int EXE_CMD_W = 4,
  parameter int BR_SQUASH = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_if_valid,
  output logic                 o_if_ready,
  input  logic [31:0]          i_instruction,
  input  logic [EXE_CMD_W-1:0] i_ctl_exe_cmd,
  input  logic [1:0]           i_ctl_br_type,
  input  logic                 i_ctl_is_branch,
  input  logic                 i_ctl_is_imm,
  input  logic                 i_ctl_st_or_bne,
  input  logic                 i_ctl_mem_r_en,
  input  logic                 i_ctl_mem_w_en,
  input  logic                 i_ctl_wb_en,
  output logic [4:0]           o_src1,
  output logic [4:0]           o_src2,
  input  logic [DATA_W-1:0]    i_reg1val,
  input  logic [DATA_W-1:0]    i_reg2val,
  output logic                 o_br_taken,
  output logic                 o_ex_valid,
  input  logic                 i_ex_ready,
  output logic [4:0]           o_ex_dest,
  output logic [DATA_W-1:0]    o_ex_val1,
  output logic [DATA_W-1:0]    o_ex_val2,
  output logic [DATA_W-1:0]    o_ex_reg2,
  output logic [EXE_CMD_W-1:0] o_ex_exe_cmd,
  output logic                 o_ex_mem_r_en,
  output logic                 o_ex_mem_w_en,
  output logic                 o_ex_wb_en,
  output logic [4:0]           o_ex_fw_src2
);

  localparam logic [1:0] LP_SQ_LOAD = 2'(BR_SQUASH);

  logic                 r_ex_valid;
  logic [4:0]           r_ex_dest;
  logic [DATA_W-1:0]    r_ex_val1;
  logic [DATA_W-1:0]    r_ex_val2;
  logic [DATA_W-1:0]    r_ex_reg2;
  logic [EXE_CMD_W-1:0] r_ex_exe_cmd;
  logic                 r_ex_mem_r_en;
  logic                 r_ex_mem_w_en;
  logic                 r_ex_wb_en;
  logic [4:0]           r_ex_fw_src2;
  logic [1:0]           r_sq_cnt;

  logic                 w_stall_dn;
  logic                 w_hazard;
  logic                 w_sq_zero;
  logic                 w_accept;
  logic                 w_live;
  logic                 w_cond;
  logic [DATA_W-1:0]    w_imm_ext;
  logic                 w_unused_opcode;

  assign w_unused_opcode = ^i_instruction[31:26];

  assign o_src1 = i_instruction[20:16];
  assign o_src2 = i_ctl_st_or_bne ? i_instruction[25:21] : i_instruction[15:11];

  always_comb begin
    w_imm_ext       = {DATA_W{i_instruction[15]}};
    w_imm_ext[15:0] = i_instruction[15:0];
  end

`ifdef ID_HAZARD_EN
  logic w_uses2;
  assign w_uses2  = ~i_ctl_is_imm | i_ctl_st_or_bne;
  assign w_hazard = r_ex_valid & r_ex_mem_r_en & (r_ex_dest != 5'd0) &
                    ((r_ex_dest == o_src1) | (w_uses2 & (r_ex_dest == o_src2)));
`else
  assign w_hazard = 1'b0;
`endif

  always_comb begin
    w_cond = 1'b0;
    case (i_ctl_br_type)
      2'b00:   w_cond = (i_reg1val == '0);
      2'b01:   w_cond = (i_reg1val != i_reg2val);
      2'b10:   w_cond = 1'b1;
      default: w_cond = 1'b0;
    endcase
  end

  // Instructions being squashed are discarded anyway, so they never wait on a hazard.
  assign w_stall_dn = r_ex_valid & ~i_ex_ready;
  assign w_sq_zero  = (r_sq_cnt == 2'd0);
  assign o_if_ready = ~w_stall_dn & (~w_hazard | ~w_sq_zero);
  assign w_accept   = i_if_valid & o_if_ready;
  assign w_live     = w_accept & w_sq_zero;
  assign o_br_taken = w_live & i_ctl_is_branch & w_cond;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ex_valid    <= 1'b0;
      r_ex_dest     <= '0;
      r_ex_val1     <= '0;
      r_ex_val2     <= '0;
      r_ex_reg2     <= '0;
      r_ex_exe_cmd  <= '0;
      r_ex_mem_r_en <= 1'b0;
      r_ex_mem_w_en <= 1'b0;
      r_ex_wb_en    <= 1'b0;
      r_ex_fw_src2  <= '0;
      r_sq_cnt      <= 2'd0;
    end else begin
      if (!w_stall_dn) begin
        r_ex_valid <= w_live;
        if (w_live) begin
          r_ex_dest     <= i_instruction[25:21];
          r_ex_val1     <= i_reg1val;
          r_ex_val2     <= i_ctl_is_imm ? w_imm_ext : i_reg2val;
          r_ex_reg2     <= i_reg2val;
          r_ex_exe_cmd  <= i_ctl_exe_cmd;
          r_ex_mem_r_en <= i_ctl_mem_r_en;
          r_ex_mem_w_en <= i_ctl_mem_w_en;
          r_ex_wb_en    <= i_ctl_wb_en;
          r_ex_fw_src2  <= i_ctl_is_imm ? i_instruction[15:11] : 5'd0;
        end
      end
      if (o_br_taken) begin
        r_sq_cnt <= LP_SQ_LOAD;
      end else if (w_accept && !w_sq_zero) begin
        r_sq_cnt <= r_sq_cnt - 2'd1;
      end
    end
  end

  assign o_ex_valid    = r_ex_valid;
  assign o_ex_dest     = r_ex_dest;
  assign o_ex_val1     = r_ex_val1;
  assign o_ex_val2     = r_ex_val2;
  assign o_ex_reg2     = r_ex_reg2;
  assign o_ex_exe_cmd  = r_ex_exe_cmd;
  assign o_ex_mem_r_en = r_ex_mem_r_en;
  assign o_ex_mem_w_en = r_ex_mem_w_en;
  assign o_ex_wb_en    = r_ex_wb_en;
  assign o_ex_fw_src2  = r_ex_fw_src2;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe (DATA_W=32, BR_SQUASH=2): directed scenarios plus a random run
// scored against a queue-based model of the instructions EXE should receive.
module tb_id_stage_pipe;

  localparam int SQ = 2;

  typedef struct packed {
    logic [4:0]  dest;
    logic [31:0] val1;
    logic [31:0] val2;
    logic [31:0] reg2;
    logic [3:0]  cmd;
    logic        mr;
    logic        mw;
    logic        wb;
    logic [4:0]  fw;
  } pay_t;

  logic        clk, rst_n;
  logic        if_valid, if_ready;
  logic [31:0] instruction;
  logic [3:0]  ctl_exe_cmd;
  logic [1:0]  ctl_br_type;
  logic        ctl_is_branch, ctl_is_imm, ctl_st_or_bne, ctl_mem_r_en, ctl_mem_w_en, ctl_wb_en;
  logic [4:0]  src1, src2;
  logic [31:0] reg1val, reg2val;
  logic        br_taken, ex_valid, ex_ready;
  logic [4:0]  ex_dest, ex_fw_src2;
  logic [31:0] ex_val1, ex_val2, ex_reg2;
  logic [3:0]  ex_exe_cmd;
  logic        ex_mem_r_en, ex_mem_w_en, ex_wb_en;

  int n_vec = 0;
  int n_err = 0;

  id_stage_pipe #(.DATA_W(32), .EXE_CMD_W(4), .BR_SQUASH(SQ)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_if_valid(if_valid), .o_if_ready(if_ready), .i_instruction(instruction),
    .i_ctl_exe_cmd(ctl_exe_cmd), .i_ctl_br_type(ctl_br_type), .i_ctl_is_branch(ctl_is_branch),
    .i_ctl_is_imm(ctl_is_imm), .i_ctl_st_or_bne(ctl_st_or_bne), .i_ctl_mem_r_en(ctl_mem_r_en),
    .i_ctl_mem_w_en(ctl_mem_w_en), .i_ctl_wb_en(ctl_wb_en),
    .o_src1(src1), .o_src2(src2), .i_reg1val(reg1val), .i_reg2val(reg2val),
    .o_br_taken(br_taken), .o_ex_valid(ex_valid), .i_ex_ready(ex_ready),
    .o_ex_dest(ex_dest), .o_ex_val1(ex_val1), .o_ex_val2(ex_val2), .o_ex_reg2(ex_reg2),
    .o_ex_exe_cmd(ex_exe_cmd), .o_ex_mem_r_en(ex_mem_r_en), .o_ex_mem_w_en(ex_mem_w_en),
    .o_ex_wb_en(ex_wb_en), .o_ex_fw_src2(ex_fw_src2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk_instr(input logic [4:0] dest, input logic [4:0] s1,
                                           input logic [15:0] imm);
    return {6'd0, dest, s1, imm};
  endfunction

  task automatic idle();
    if_valid = 1'b0; instruction = '0; ctl_exe_cmd = '0; ctl_br_type = 2'b11;
    ctl_is_branch = 1'b0; ctl_is_imm = 1'b0; ctl_st_or_bne = 1'b0; ctl_mem_r_en = 1'b0;
    ctl_mem_w_en = 1'b0; ctl_wb_en = 1'b0; reg1val = '0; reg2val = '0; ex_ready = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0; if_valid = 1'b1; instruction = mk_instr(5'd3, 5'd4, 16'h0010);
    reg1val = 32'hDEAD_BEEF;
    @(posedge clk); @(negedge clk); #1;
    n_vec++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL rst_ex_valid got=%b exp=0", ex_valid); end
    n_vec++; if (ex_val1 !== 32'd0) begin n_err++; $display("FAIL rst_ex_val1 got=%h exp=0", ex_val1); end
    n_vec++; if (ex_dest !== 5'd0) begin n_err++; $display("FAIL rst_ex_dest got=%0d exp=0", ex_dest); end
    n_vec++; if (if_ready !== 1'b1) begin n_err++; $display("FAIL rst_if_ready got=%b exp=1", if_ready); end
    rst_n = 1'b1; reg1val = 32'h0000_1234;
    #1;
    n_vec++; if (if_ready !== 1'b1) begin n_err++; $display("FAIL rel_if_ready got=%b exp=1", if_ready); end
    tick();
    n_vec++; if (ex_valid !== 1'b1) begin n_err++; $display("FAIL rel_ex_valid got=%b exp=1", ex_valid); end
    n_vec++; if (ex_val1 !== 32'h1234) begin n_err++; $display("FAIL rel_ex_val1 got=%h exp=1234", ex_val1); end
    n_vec++; if (ex_dest !== 5'd3) begin n_err++; $display("FAIL rel_ex_dest got=%0d exp=3", ex_dest); end
    if_valid = 1'b0;
    tick();
    n_vec++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL rel_bubble got=%b exp=0", ex_valid); end
  endtask

  task automatic test_immediate();
    do_reset();
    if_valid = 1'b1; ctl_is_imm = 1'b1; instruction = mk_instr(5'd7, 5'd2, 16'hFFF0);
    reg2val = 32'h55; ctl_exe_cmd = 4'hA; ctl_wb_en = 1'b1;
    tick();
    n_vec++; if (ex_val2 !== 32'hFFFF_FFF0) begin n_err++; $display("FAIL imm_neg_val2 got=%h exp=fffffff0", ex_val2); end
    n_vec++; if (ex_fw_src2 !== 5'd31) begin n_err++; $display("FAIL imm_fw_src2 got=%0d exp=31", ex_fw_src2); end
    n_vec++; if ({ex_reg2, ex_dest, ex_exe_cmd, ex_wb_en} !== {32'h55, 5'd7, 4'hA, 1'b1}) begin
      n_err++; $display("FAIL imm_fields got=%h/%0d/%h/%b exp=55/7/a/1", ex_reg2, ex_dest, ex_exe_cmd, ex_wb_en);
    end
    instruction = mk_instr(5'd9, 5'd2, 16'h0812);
    tick();
    n_vec++; if ({ex_val2, ex_fw_src2} !== {32'h0000_0812, 5'd1}) begin
      n_err++; $display("FAIL imm_pos got=%h/%0d exp=00000812/1", ex_val2, ex_fw_src2);
    end
    ctl_is_imm = 1'b0; reg2val = 32'h99;
    tick();
    n_vec++; if ({ex_val2, ex_fw_src2} !== {32'h99, 5'd0}) begin
      n_err++; $display("FAIL reg_val2 got=%h/%0d exp=00000099/0", ex_val2, ex_fw_src2);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    if_valid = 1'b1; ctl_mem_r_en = 1'b1; ctl_is_imm = 1'b1; instruction = mk_instr(5'd5, 5'd1, 16'h0004);
    tick();
    ctl_mem_r_en = 1'b0; ctl_is_imm = 1'b0; instruction = mk_instr(5'd6, 5'd5, 16'h1800);
    #1;
`ifdef ID_HAZARD_EN
    n_vec++; if (if_ready !== 1'b0) begin n_err++; $display("FAIL lu_stall got=%b exp=0", if_ready); end
    tick();
    n_vec++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL lu_bubble got=%b exp=0", ex_valid); end
    #1;
`endif
    n_vec++; if (if_ready !== 1'b1) begin n_err++; $display("FAIL lu_go got=%b exp=1", if_ready); end
    tick();
    n_vec++; if ({ex_valid, ex_dest} !== {1'b1, 5'd6}) begin
      n_err++; $display("FAIL lu_load got=%b/%0d exp=1/6", ex_valid, ex_dest);
    end
    ctl_mem_r_en = 1'b1; ctl_is_imm = 1'b1; instruction = mk_instr(5'd0, 5'd1, 16'h0004);
    tick();
    ctl_mem_r_en = 1'b0; ctl_is_imm = 1'b0; instruction = mk_instr(5'd8, 5'd0, 16'h0000);
    #1;
    n_vec++; if (if_ready !== 1'b1) begin n_err++; $display("FAIL lu_dest0 got=%b exp=1", if_ready); end
    tick();
    ctl_mem_r_en = 1'b1; ctl_is_imm = 1'b1; instruction = mk_instr(5'd5, 5'd1, 16'h0004);
    tick();
    ctl_mem_r_en = 1'b0; instruction = mk_instr(5'd10, 5'd2, 16'h2800);
    #1;
    n_vec++; if (if_ready !== 1'b1) begin n_err++; $display("FAIL lu_imm_src2 got=%b exp=1", if_ready); end
    tick();
    n_vec++; if ({ex_valid, ex_dest} !== {1'b1, 5'd10}) begin
      n_err++; $display("FAIL lu_imm_load got=%b/%0d exp=1/10", ex_valid, ex_dest);
    end
  endtask

  task automatic test_branch_squash();
    do_reset();
    if_valid = 1'b1; ctl_is_branch = 1'b1; ctl_br_type = 2'b01; reg1val = 32'd3; reg2val = 32'd4;
    instruction = mk_instr(5'd1, 5'd2, 16'h1800);
    #1;
    n_vec++; if (br_taken !== 1'b1) begin n_err++; $display("FAIL bne_taken got=%b exp=1", br_taken); end
    tick();
    n_vec++; if ({ex_valid, ex_val1} !== {1'b1, 32'd3}) begin
      n_err++; $display("FAIL bne_loaded got=%b/%h exp=1/3", ex_valid, ex_val1);
    end
    ctl_br_type = 2'b10; reg1val = 32'hA;
    #1;
    n_vec++; if ({br_taken, if_ready} !== 2'b01) begin
      n_err++; $display("FAIL sq_no_br got=%b/%b exp=0/1", br_taken, if_ready);
    end
    tick();
    n_vec++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL sq_first got=%b exp=0", ex_valid); end
    if_valid = 1'b0;
    tick();
    if_valid = 1'b1; ctl_is_branch = 1'b0; reg1val = 32'hB;
    tick();
    n_vec++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL sq_second got=%b exp=0", ex_valid); end
    reg1val = 32'hC;
    tick();
    n_vec++; if ({ex_valid, ex_val1} !== {1'b1, 32'hC}) begin
      n_err++; $display("FAIL sq_third got=%b/%h exp=1/c", ex_valid, ex_val1);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    if_valid = 1'b1; reg1val = 32'hAA; instruction = mk_instr(5'd4, 5'd1, 16'h0000);
    tick();
    ex_ready = 1'b0; ctl_is_branch = 1'b1; ctl_br_type = 2'b10; reg1val = 32'hBB;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++; if ({if_ready, br_taken, ex_valid, ex_val1, ex_dest} !== {1'b0, 1'b0, 1'b1, 32'hAA, 5'd4}) begin
        n_err++; $display("FAIL bp_hold%0d got=%b/%b/%b/%h/%0d exp=0/0/1/aa/4", i, if_ready, br_taken, ex_valid, ex_val1, ex_dest);
      end
      tick();
    end
    ex_ready = 1'b1;
    #1;
    n_vec++; if ({if_ready, br_taken} !== 2'b11) begin
      n_err++; $display("FAIL bp_release got=%b/%b exp=1/1", if_ready, br_taken);
    end
    tick();
    n_vec++; if ({ex_valid, ex_val1} !== {1'b1, 32'hBB}) begin
      n_err++; $display("FAIL bp_loaded got=%b/%h exp=1/bb", ex_valid, ex_val1);
    end
  endtask

  task automatic test_bez_not_taken();
    do_reset();
    if_valid = 1'b1; ctl_is_branch = 1'b1; ctl_br_type = 2'b00; reg1val = 32'd1;
    #1;
    n_vec++; if (br_taken !== 1'b0) begin n_err++; $display("FAIL bez_nt got=%b exp=0", br_taken); end
    ctl_br_type = 2'b01; reg2val = 32'd1;
    #1;
    n_vec++; if (br_taken !== 1'b0) begin n_err++; $display("FAIL bne_nt got=%b exp=0", br_taken); end
    ctl_br_type = 2'b00; reg1val = 32'd0;
    #1;
    n_vec++; if (br_taken !== 1'b1) begin n_err++; $display("FAIL bez_t got=%b exp=1", br_taken); end
    ctl_br_type = 2'b11;
    #1;
    n_vec++; if (br_taken !== 1'b0) begin n_err++; $display("FAIL never_t got=%b exp=0", br_taken); end
    ctl_br_type = 2'b00; reg1val = 32'd1;
    tick();
    ctl_is_branch = 1'b0; reg1val = 32'h77;
    tick();
    n_vec++; if ({ex_valid, ex_val1} !== {1'b1, 32'h77}) begin
      n_err++; $display("FAIL bez_next got=%b/%h exp=1/77", ex_valid, ex_val1);
    end
    ctl_is_branch = 1'b1; ctl_br_type = 2'b11; reg1val = 32'h78;
    tick();
    ctl_is_branch = 1'b0; reg1val = 32'h79;
    tick();
    n_vec++; if ({ex_valid, ex_val1} !== {1'b1, 32'h79}) begin
      n_err++; $display("FAIL never_next got=%b/%h exp=1/79", ex_valid, ex_val1);
    end
  endtask

  task automatic test_reset_mid_squash();
    do_reset();
    if_valid = 1'b1; ctl_is_branch = 1'b1; ctl_br_type = 2'b10; reg1val = 32'h11;
    tick();
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if ({ex_valid, ex_val1} !== {1'b0, 32'h0}) begin
      n_err++; $display("FAIL async_rst got=%b/%h exp=0/0", ex_valid, ex_val1);
    end
    @(negedge clk);
    rst_n = 1'b1; ctl_is_branch = 1'b0; reg1val = 32'h5A;
    tick();
    n_vec++; if ({ex_valid, ex_val1} !== {1'b1, 32'h5A}) begin
      n_err++; $display("FAIL rst_clears_sq got=%b/%h exp=1/5a", ex_valid, ex_val1);
    end
  endtask

  task automatic test_random();
    pay_t q[$];
    pay_t got, p;
    int   sq;
    logic e_haz, e_ready, e_acc, e_cond, e_br;
    logic [4:0] e_src2;
    do_reset();
    sq = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if_valid = ($urandom_range(0, 3) != 0);
      ex_ready = ($urandom_range(0, 9) < 7);
      instruction = $urandom;
      instruction[25:21] = 5'($urandom_range(0, 3));
      instruction[20:16] = 5'($urandom_range(0, 3));
      instruction[15:11] = 5'($urandom_range(0, 3));
      ctl_exe_cmd = 4'($urandom); ctl_br_type = 2'($urandom);
      ctl_is_branch = ($urandom_range(0, 3) == 0);
      ctl_is_imm = 1'($urandom); ctl_st_or_bne = 1'($urandom);
      ctl_mem_r_en = 1'($urandom); ctl_mem_w_en = 1'($urandom); ctl_wb_en = 1'($urandom);
      reg1val = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 2));
      reg2val = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 2));
      #1;
      e_src2 = ctl_st_or_bne ? instruction[25:21] : instruction[15:11];
`ifdef ID_HAZARD_EN
      e_haz = (q.size() != 0) && q[0].mr && (q[0].dest != 0) &&
              ((q[0].dest == instruction[20:16]) || ((!ctl_is_imm || ctl_st_or_bne) && (q[0].dest == e_src2)));
`else
      e_haz = 1'b0;
`endif
      e_ready = !((q.size() != 0) && !ex_ready) && (!e_haz || sq != 0);
      e_acc = if_valid && e_ready;
      case (ctl_br_type)
        2'b00:   e_cond = (reg1val == 0);
        2'b01:   e_cond = (reg1val != reg2val);
        2'b10:   e_cond = 1'b1;
        default: e_cond = 1'b0;
      endcase
      e_br = e_acc && (sq == 0) && ctl_is_branch && e_cond;
      n_vec++; if (ex_valid !== (q.size() != 0)) begin n_err++; $display("FAIL rnd_ex_valid cyc=%0d got=%b exp=%b", cyc, ex_valid, q.size() != 0); end
      n_vec++; if (if_ready !== e_ready) begin n_err++; $display("FAIL rnd_if_ready cyc=%0d got=%b exp=%b", cyc, if_ready, e_ready); end
      n_vec++; if (br_taken !== e_br) begin n_err++; $display("FAIL rnd_br_taken cyc=%0d got=%b exp=%b", cyc, br_taken, e_br); end
      n_vec++; if ({src1, src2} !== {instruction[20:16], e_src2}) begin
        n_err++; $display("FAIL rnd_src cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, src1, src2, instruction[20:16], e_src2);
      end
      if (q.size() != 0) begin
        got = {ex_dest, ex_val1, ex_val2, ex_reg2, ex_exe_cmd, ex_mem_r_en, ex_mem_w_en, ex_wb_en, ex_fw_src2};
        n_vec++; if (got !== q[0]) begin n_err++; $display("FAIL rnd_payload cyc=%0d got=%h exp=%h", cyc, got, q[0]); end
      end
      @(posedge clk);
      if ((q.size() != 0) && ex_ready) void'(q.pop_front());
      if (e_acc) begin
        if (sq == 0) begin
          p.dest = instruction[25:21];
          p.val1 = reg1val;
          p.val2 = ctl_is_imm ? {{16{instruction[15]}}, instruction[15:0]} : reg2val;
          p.reg2 = reg2val;
          p.cmd  = ctl_exe_cmd;
          p.mr   = ctl_mem_r_en;
          p.mw   = ctl_mem_w_en;
          p.wb   = ctl_wb_en;
          p.fw   = ctl_is_imm ? instruction[15:11] : 5'd0;
          q.push_back(p);
        end
        if (e_br) sq = SQ;
        else if (sq > 0) sq--;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout vectors=%0d", n_vec);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    test_reset();
    test_immediate();
    test_load_use();
    test_branch_squash();
    test_backpressure();
    test_bez_not_taken();
    test_reset_mid_squash();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
